// File: rtl/biu_mem_responder.sv
// Memory-side slave for the BIU cs/sel/ready handshake: word reads/writes and two-beat fetches.
// Each ready beat follows WAIT_STATES+1 cycles in WAIT. Dropping cs aborts a transaction; HOLD waits for cs release.
module biu_mem_responder #(
    parameter int AW          = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [1:0]  sel,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    output logic [31:0] ir_out,
    output logic        ir_valid,
    output logic        busy,
    output logic        err
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

    localparam logic [1:0]    SEL_RSVD = 2'b00;
    localparam logic [1:0]    SEL_WR   = 2'b10;
    localparam logic [1:0]    SEL_IF   = 2'b11;
    localparam logic [3:0]    WS_INIT  = 4'(WAIT_STATES);
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_beat;
    logic [AW-1:0]   r_addr;
    logic [1:0]      r_sel;
    logic [15:0]     r_wdata;
    logic [15:0]     r_rdata;
    logic            r_ready;
    logic [31:0]     r_ir_out;
    logic            r_ir_valid;
    logic            r_busy;
    logic            r_err;
    logic [15:0]     r_mem [0:(1<<AW)-1];

    logic            w_we;
    logic [15:0]     w_mem_q;
    logic            w_addr_unused;

    assign w_mem_q       = r_mem[r_addr];
    assign w_addr_unused = ^addr;
    // A write only lands if cs is still held when RESP completes.
    assign w_we          = (r_state == S_RESP) && cs && (r_sel == SEL_WR);

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_beat     <= 1'b0;
            r_addr     <= '0;
            r_sel      <= 2'b00;
            r_wdata    <= 16'h0000;
            r_rdata    <= 16'h0000;
            r_ready    <= 1'b0;
            r_ir_out   <= 32'h0000_0000;
            r_ir_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ready    <= 1'b0;
            r_ir_valid <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cs) begin
                        r_busy <= 1'b1;
                        if (sel == SEL_RSVD) begin
                            r_err   <= 1'b1;
                            r_state <= S_HOLD;
                        end else begin
                            r_addr  <= addr[AW-1:0];
                            r_sel   <= sel;
                            r_wdata <= wdata;
                            r_cnt   <= WS_INIT;
                            r_beat  <= 1'b0;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!cs) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= S_RESP;
                        r_ready <= 1'b1;
                        if (r_sel != SEL_WR) begin
                            r_rdata <= w_mem_q;
                        end
                        // r_rdata still holds the first fetch beat here.
                        if (r_sel == SEL_IF && r_beat) begin
                            r_ir_out   <= {r_rdata, w_mem_q};
                            r_ir_valid <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (!cs) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_sel == SEL_IF && !r_beat) begin
                        r_addr  <= r_addr + ADDR_ONE;
                        r_beat  <= 1'b1;
                        r_cnt   <= WS_INIT;
                        r_state <= S_WAIT;
                    end else begin
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!cs) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rdata    = r_rdata;
    assign ready    = r_ready;
    assign ir_out   = r_ir_out;
    assign ir_valid = r_ir_valid;
    assign busy     = r_busy;
    assign err      = r_err;
endmodule
